bus_cycle_ctrl: RTL and testbench

BUS_CYCLE_CTRL -- requirements
Module: bus_cycle_ctrl

---
 rtl/bus_cycle_ctrl.sv | 215 +++++++++++++++++++++
 tb/tb_bus_cycle_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_cycle_ctrl.sv
// 8051-style external bus cycle controller: 12-clk machine cycles, arbitration
// at tick 0, multiplexed P0 address/data bus with ALE/PSEN/RD/WR strobes.
module bus_cycle_ctrl #(
    parameter logic [15:0] IROM_TOP = 16'h0FFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        EA,
    input  logic        fetch_req,
    input  logic [15:0] fetch_addr,
    input  logic        data_req,
    input  logic        data_we,
    input  logic [15:0] data_addr,
    input  logic [7:0]  data_wdata,
    input  logic [7:0]  irom_data,
    input  logic [7:0]  P0_in,
    output logic        fetch_ack,
    output logic        data_ack,
    output logic [7:0]  rdata,
    output logic [11:0] irom_addr,
    output logic        ALE,
    output logic        PSEN,
    output logic        RD,
    output logic        WR,
    output logic [7:0]  P0_out,
    output logic        P0_oe,
    output logic [7:0]  P2_out
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_IFETCH = 3'd1,
        ST_XFETCH = 3'd2,
        ST_XREAD  = 3'd3,
        ST_XWRITE = 3'd4
    } cyc_state_t;

    cyc_state_t  state_q, state_d;
    logic [3:0]  tick_q, tick_d;
    logic        run_q, run_d;
    logic [15:0] addr_q, addr_d;
    logic [7:0]  wdata_q, wdata_d;

    logic        ale_q, ale_d;
    logic        psen_q, psen_d;
    logic        rd_q, rd_d;
    logic        wr_q, wr_d;
    logic [7:0]  p0_out_q, p0_out_d;
    logic        p0_oe_q, p0_oe_d;
    logic [7:0]  p2_out_q, p2_out_d;
    logic [11:0] irom_addr_q, irom_addr_d;
    logic        fetch_ack_q, fetch_ack_d;
    logic        data_ack_q, data_ack_d;
    logic [7:0]  rdata_q, rdata_d;
    logic        is_ext;

    // State register: tick counter, cycle type and latched access operands.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            tick_q  <= 4'd0;
            run_q   <= 1'b0;
            addr_q  <= 16'h0000;
            wdata_q <= 8'h00;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            run_q   <= run_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    // Next-state: advance tick; on entry to tick 0 arbitrate (data beats fetch).
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        run_d   = 1'b1;
        // The first edge after reset release enters tick 0 directly.
        if (!run_q || tick_q == 4'd11) begin
            tick_d = 4'd0;
        end else begin
            tick_d = tick_q + 4'd1;
        end
        if (tick_d == 4'd0) begin
            if (data_req) begin
                state_d = data_we ? ST_XWRITE : ST_XREAD;
                addr_d  = data_addr;
                wdata_d = data_wdata;
            end else if (fetch_req) begin
                state_d = (EA && (fetch_addr <= IROM_TOP)) ? ST_IFETCH : ST_XFETCH;
                addr_d  = fetch_addr;
            end else begin
                state_d = ST_IDLE;
            end
        end else begin
            state_d = state_q;
        end
    end

    // Output decode: values for the tick being entered, so pins come straight from flops.
    always_comb begin
        ale_d       = (tick_d <= 4'd1);
        psen_d      = 1'b1;
        rd_d        = 1'b1;
        wr_d        = 1'b1;
        p0_out_d    = p0_out_q;
        p0_oe_d     = 1'b0;
        p2_out_d    = p2_out_q;
        irom_addr_d = irom_addr_q;
        fetch_ack_d = 1'b0;
        data_ack_d  = 1'b0;
        rdata_d     = rdata_q;
        is_ext      = (state_d == ST_XFETCH) || (state_d == ST_XREAD) || (state_d == ST_XWRITE);

        case (state_d)
            ST_IFETCH: begin
                irom_addr_d = addr_d[11:0];
                fetch_ack_d = (tick_d == 4'd11);
            end
            ST_XFETCH: begin
                psen_d      = !((tick_d >= 4'd3) && (tick_d <= 4'd8));
                fetch_ack_d = (tick_d == 4'd11);
            end
            ST_XREAD: begin
                rd_d       = !((tick_d >= 4'd3) && (tick_d <= 4'd10));
                data_ack_d = (tick_d == 4'd11);
            end
            ST_XWRITE: begin
                wr_d       = !((tick_d >= 4'd3) && (tick_d <= 4'd10));
                data_ack_d = (tick_d == 4'd11);
            end
            default: begin
                psen_d = 1'b1;
            end
        endcase

        if (is_ext) begin
            p2_out_d = addr_d[15:8];
            if (tick_d <= 4'd2) begin
                p0_out_d = addr_d[7:0];
                p0_oe_d  = 1'b1;
            end else if (state_d == ST_XWRITE) begin
                p0_out_d = wdata_d;
                p0_oe_d  = 1'b1;
            end else begin
                p0_oe_d = 1'b0;
            end
        end else begin
            p0_oe_d = 1'b0;
        end

        // Read data is captured at the end of the current tick, so it keys off _q.
        case (state_q)
            ST_IFETCH: begin
                if (tick_q == 4'd8) rdata_d = irom_data;
                else                rdata_d = rdata_q;
            end
            ST_XFETCH: begin
                if (tick_q == 4'd8) rdata_d = P0_in;
                else                rdata_d = rdata_q;
            end
            ST_XREAD: begin
                if (tick_q == 4'd10) rdata_d = P0_in;
                else                 rdata_d = rdata_q;
            end
            default: begin
                rdata_d = rdata_q;
            end
        endcase
    end

    // Output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ale_q       <= 1'b0;
            psen_q      <= 1'b1;
            rd_q        <= 1'b1;
            wr_q        <= 1'b1;
            p0_out_q    <= 8'h00;
            p0_oe_q     <= 1'b0;
            p2_out_q    <= 8'h00;
            irom_addr_q <= 12'h000;
            fetch_ack_q <= 1'b0;
            data_ack_q  <= 1'b0;
            rdata_q     <= 8'h00;
        end else begin
            ale_q       <= ale_d;
            psen_q      <= psen_d;
            rd_q        <= rd_d;
            wr_q        <= wr_d;
            p0_out_q    <= p0_out_d;
            p0_oe_q     <= p0_oe_d;
            p2_out_q    <= p2_out_d;
            irom_addr_q <= irom_addr_d;
            fetch_ack_q <= fetch_ack_d;
            data_ack_q  <= data_ack_d;
            rdata_q     <= rdata_d;
        end
    end

    assign ALE       = ale_q;
    assign PSEN      = psen_q;
    assign RD        = rd_q;
    assign WR        = wr_q;
    assign P0_out    = p0_out_q;
    assign P0_oe     = p0_oe_q;
    assign P2_out    = p2_out_q;
    assign irom_addr = irom_addr_q;
    assign fetch_ack = fetch_ack_q;
    assign data_ack  = data_ack_q;
    assign rdata     = rdata_q;

endmodule

// File: tb/tb_bus_cycle_ctrl.sv
// Self-checking bench for bus_cycle_ctrl: per-tick strobe checks plus an ack
// scoreboard filled when requests are issued and drained when acks appear.
module tb_bus_cycle_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        EA = 1'b0;
    logic        fetch_req = 1'b0;
    logic [15:0] fetch_addr = 16'h0000;
    logic        data_req = 1'b0;
    logic        data_we = 1'b0;
    logic [15:0] data_addr = 16'h0000;
    logic [7:0]  data_wdata = 8'h00;
    logic [7:0]  irom_data = 8'h00;
    logic [7:0]  P0_in = 8'h00;
    logic        fetch_ack, data_ack, ALE, PSEN, RD, WR, P0_oe;
    logic [7:0]  rdata, P0_out, P2_out;
    logic [11:0] irom_addr;

    always #5 clk = ~clk;

    bus_cycle_ctrl #(.IROM_TOP(16'h0FFF)) dut (
        .clk(clk), .reset(reset), .EA(EA),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr),
        .data_req(data_req), .data_we(data_we), .data_addr(data_addr),
        .data_wdata(data_wdata), .irom_data(irom_data), .P0_in(P0_in),
        .fetch_ack(fetch_ack), .data_ack(data_ack), .rdata(rdata),
        .irom_addr(irom_addr), .ALE(ALE), .PSEN(PSEN), .RD(RD), .WR(WR),
        .P0_out(P0_out), .P0_oe(P0_oe), .P2_out(P2_out)
    );

    typedef struct packed {
        logic       is_data;
        logic [7:0] rdata;
    } exp_t;

    exp_t       sb_q[$];
    int         checks = 0;
    int         failures = 0;
    int         tb_tick = 0;
    bit         started = 1'b0;
    logic [7:0] last_rdata = 8'h00;
    logic [7:0] last_p0 = 8'h00;
    logic [7:0] last_p2 = 8'h00;

    logic [15:0] f_addr [5] = '{16'h1234, 16'h0010, 16'h1000, 16'h0FFF, 16'h0010};
    logic        f_ea   [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic        f_int  [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [7:0]  f_byte [5] = '{8'hA5, 8'h74, 8'h3C, 8'hE1, 8'h96};

    // Advance one clock, track the bench tick model, drain the ack scoreboard.
    task automatic step();
        exp_t e;
        @(posedge clk);
        if (!reset) begin
            started = 1'b0;
            tb_tick = 0;
        end else if (!started) begin
            started = 1'b1;
            tb_tick = 0;
        end else begin
            tb_tick = (tb_tick + 1) % 12;
        end
        @(negedge clk);
        checks++;
        if (int'(PSEN) + int'(RD) + int'(WR) < 2) begin
            failures++;
            $display("FAIL strobe_excl tick=%0d got PSEN=%b RD=%b WR=%b required at most one low",
                     tb_tick, PSEN, RD, WR);
        end
        if (fetch_ack || data_ack) begin
            checks++;
            if (sb_q.size() == 0 || tb_tick != 11 || (fetch_ack && data_ack)) begin
                failures++;
                $display("FAIL unexpected_ack tick=%0d got fetch_ack=%b data_ack=%b pending=%0d required ack only at tick 11 for a pending access",
                         tb_tick, fetch_ack, data_ack, sb_q.size());
            end else begin
                e = sb_q.pop_front();
                if (data_ack !== e.is_data || rdata !== e.rdata) begin
                    failures++;
                    $display("FAIL ack_data got data_ack=%b rdata=%h required data_ack=%b rdata=%h",
                             data_ack, rdata, e.is_data, e.rdata);
                end
                last_rdata = e.rdata;
            end
        end
    endtask

    task automatic wait_tick11();
        for (int i = 0; i < 24 && tb_tick != 11; i++) step();
        checks++;
        if (tb_tick != 11) begin
            failures++;
            $display("FAIL wait_tick11 got tick=%0d required 11", tb_tick);
        end
    endtask

    task automatic check_drained(input string name);
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL %s_missing_ack got %0d pending required 0", name, sb_q.size());
        end
        sb_q.delete();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #2 reset = 1'b0;
        #20;
        checks++;
        if ({ALE, PSEN, RD, WR, P0_oe, fetch_ack, data_ack} !== 7'b0111000 ||
            rdata !== 8'h00 || P0_out !== 8'h00 || P2_out !== 8'h00 || irom_addr !== 12'h000) begin
            failures++;
            $display("FAIL reset_values got ctl=%b rdata=%h P0=%h P2=%h irom=%h required ctl=0111000 all zero",
                     {ALE, PSEN, RD, WR, P0_oe, fetch_ack, data_ack}, rdata, P0_out, P2_out, irom_addr);
        end
        @(negedge clk);
        reset = 1'b1;
        for (int t = 0; t < 12; t++) begin
            step();
            checks++;
            if ({ALE, PSEN, RD, WR, P0_oe} !== {(t <= 1), 4'b1110} || P0_out !== 8'h00 || P2_out !== 8'h00) begin
                failures++;
                $display("FAIL idle_cycle t=%0d got ctl=%b P0=%h P2=%h required ctl=%b P0=00 P2=00",
                         t, {ALE, PSEN, RD, WR, P0_oe}, P0_out, P2_out, {(t <= 1), 4'b1110});
            end
        end
    endtask

    task automatic test_fetch();
        logic ext;
        for (int k = 0; k < 5; k++) begin
            wait_tick11();
            ext        = !f_int[k];
            EA         = f_ea[k];
            fetch_addr = f_addr[k];
            fetch_req  = 1'b1;
            P0_in      = 8'h00;
            irom_data  = 8'h00;
            sb_q.push_back('{is_data: 1'b0, rdata: f_byte[k]});
            for (int t = 0; t < 12; t++) begin
                step();
                checks++;
                if ({ALE, PSEN, RD, WR, P0_oe} !==
                    {(t <= 1), !(ext && t >= 3 && t <= 8), 1'b1, 1'b1, (ext && t <= 2)}) begin
                    failures++;
                    $display("FAIL fetch%0d_ctl t=%0d got ALE,PSEN,RD,WR,OE=%b required %b", k, t,
                             {ALE, PSEN, RD, WR, P0_oe},
                             {(t <= 1), !(ext && t >= 3 && t <= 8), 1'b1, 1'b1, (ext && t <= 2)});
                end
                checks++;
                if (P2_out !== (ext ? f_addr[k][15:8] : last_p2) ||
                    ((ext && t <= 2) && P0_out !== f_addr[k][7:0]) ||
                    (!ext && P0_out !== last_p0)) begin
                    failures++;
                    $display("FAIL fetch%0d_bus t=%0d got P2=%h P0=%h required P2=%h P0=%h", k, t,
                             P2_out, P0_out, ext ? f_addr[k][15:8] : last_p2,
                             ext ? f_addr[k][7:0] : last_p0);
                end
                if (!ext) begin
                    checks++;
                    if (irom_addr !== f_addr[k][11:0]) begin
                        failures++;
                        $display("FAIL fetch%0d_irom_addr t=%0d got %h required %h", k, t,
                                 irom_addr, f_addr[k][11:0]);
                    end
                end
                if (t == 5) EA = ~EA;
                if (t == 7) begin
                    P0_in     = ext ? f_byte[k] : 8'h55;
                    irom_data = ext ? 8'h66 : f_byte[k];
                end
                if (t == 9) begin
                    P0_in     = 8'hFF;
                    irom_data = 8'hFF;
                end
            end
            fetch_req = 1'b0;
            if (ext) begin
                last_p2 = f_addr[k][15:8];
                last_p0 = f_addr[k][7:0];
            end
        end
        check_drained("fetch");
    endtask

    task automatic test_write();
        logic [7:0] p0_exp;
        wait_tick11();
        data_req   = 1'b1;
        data_we    = 1'b1;
        data_addr  = 16'h8001;
        data_wdata = 8'h5A;
        sb_q.push_back('{is_data: 1'b1, rdata: last_rdata});
        for (int t = 0; t < 12; t++) begin
            step();
            p0_exp = (t <= 2) ? 8'h01 : 8'h5A;
            checks++;
            if ({ALE, PSEN, RD, WR, P0_oe} !== {(t <= 1), 1'b1, 1'b1, !(t >= 3 && t <= 10), 1'b1} ||
                P2_out !== 8'h80 || P0_out !== p0_exp) begin
                failures++;
                $display("FAIL write t=%0d got ctl=%b P2=%h P0=%h required ctl=%b P2=80 P0=%h", t,
                         {ALE, PSEN, RD, WR, P0_oe},  P2_out, P0_out,
                         {(t <= 1), 1'b1, 1'b1, !(t >= 3 && t <= 10), 1'b1}, p0_exp);
            end
            if (t == 4) begin
                data_req   = 1'b0;
                data_wdata = 8'hFF;
                data_addr  = 16'h0000;
            end
        end
        data_we = 1'b0;
        last_p2 = 8'h80;
        last_p0 = 8'h5A;
        check_drained("write");
    endtask

    task automatic test_back_to_back();
        logic [7:0] bytes [3] = '{8'hC3, 8'hC4, 8'hA7};
        logic       rdc;
        wait_tick11();
        EA         = 1'b0;
        data_req   = 1'b1;
        data_we    = 1'b0;
        data_addr  = 16'h4321;
        fetch_req  = 1'b1;
        fetch_addr = 16'h1234;
        for (int c = 0; c < 3; c++) sb_q.push_back('{is_data: (c < 2), rdata: bytes[c]});
        for (int c = 0; c < 3; c++) begin
            rdc = (c < 2);
            for (int t = 0; t < 12; t++) begin
                step();
                checks++;
                if ({ALE, PSEN, RD, WR, P0_oe} !==
                    {(t <= 1), !(!rdc && t >= 3 && t <= 8), !(rdc && t >= 3 && t <= 10), 1'b1, (t <= 2)} ||
                    P2_out !== (rdc ? 8'h43 : 8'h12) ||
                    (t <= 2 && P0_out !== (rdc ? 8'h21 : 8'h34))) begin
                    failures++;
                    $display("FAIL b2b c=%0d t=%0d got ctl=%b P2=%h P0=%h required ctl=%b P2=%h", c, t,
                             {ALE, PSEN, RD, WR, P0_oe}, P2_out, P0_out,
                             {(t <= 1), !(!rdc && t >= 3 && t <= 8), !(rdc && t >= 3 && t <= 10), 1'b1, (t <= 2)},
                             rdc ? 8'h43 : 8'h12);
                end
                if (t == 7)  P0_in = rdc ? 8'h11 : bytes[c];
                if (t == 9)  P0_in = rdc ? bytes[c] : 8'hFF;
                if (t == 11) P0_in = 8'hFF;
            end
            if (c == 1) data_req = 1'b0;
            if (c == 2) fetch_req = 1'b0;
        end
        last_p2 = 8'h12;
        last_p0 = 8'h34;
        check_drained("b2b");
    endtask

    task automatic test_reset_mid();
        wait_tick11();
        data_req  = 1'b1;
        data_we   = 1'b0;
        data_addr = 16'h5678;
        for (int t = 0; t < 7; t++) step();
        checks++;
        if (RD !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid_pre got RD=%b required 0", RD);
        end
        reset    = 1'b0;
        data_req = 1'b0;
        #1;
        checks++;
        if ({ALE, PSEN, RD, WR, P0_oe, data_ack} !== 6'b011100 || P0_out !== 8'h00 ||
            P2_out !== 8'h00 || rdata !== 8'h00) begin
            failures++;
            $display("FAIL rst_mid_abort got ctl=%b P0=%h P2=%h rdata=%h required ctl=011100 zeros",
                     {ALE, PSEN, RD, WR, P0_oe, data_ack}, P0_out, P2_out, rdata);
        end
        repeat (3) step();
        @(negedge clk);
        reset = 1'b1;
        for (int t = 0; t < 24; t++) begin
            step();
            checks++;
            if ({ALE, PSEN, RD, WR, P0_oe} !== {(t % 12 <= 1), 4'b1110}) begin
                failures++;
                $display("FAIL rst_mid_after t=%0d got ctl=%b required %b", t,
                         {ALE, PSEN, RD, WR, P0_oe}, {(t % 12 <= 1), 4'b1110});
            end
        end
        last_rdata = 8'h00;
        check_drained("rst_mid");
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_write();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got no completion within 100000 time units");
        $fatal(1);
    end

endmodule
